// File: rtl/time_set_if.sv
// time_set_if: bundles the button inputs, live digits from the clock's digit
// counters, and the preset/load/display controls of the time-set controller.
// master: the controller side. slave: the clock/display/button side.
interface time_set_if;
  logic       btn_mode;
  logic       btn_inc;
  logic [3:0] cur_h1;
  logic [3:0] cur_h0;
  logic [3:0] cur_m1;
  logic [3:0] cur_m0;
  logic [3:0] pst_h1;
  logic [3:0] pst_h0;
  logic [3:0] pst_m1;
  logic [3:0] pst_m0;
  logic [3:0] load;
  logic       setting;
  logic [1:0] sel;
  logic       blink;

  modport master (
    input  btn_mode, btn_inc,
    input  cur_h1, cur_h0, cur_m1, cur_m0,
    output pst_h1, pst_h0, pst_m1, pst_m0,
    output load, setting, sel, blink
  );

  modport slave (
    output btn_mode, btn_inc,
    output cur_h1, cur_h0, cur_m1, cur_m0,
    input  pst_h1, pst_h0, pst_m1, pst_m0,
    input  load, setting, sel, blink
  );
endinterface

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: two-button HH:MM setting controller. Mode steps through the
// four digits, inc bumps the selected digit with 24h-aware wrap, and a final
// one-cycle COMMIT strobes all four digit counters with the edited values.
// Optional feature: define TIME_SET_TIMEOUT_EN to abandon an edit after
// TIMEOUT_CYCLES idle cycles (no load strobe). Without it edits never expire.
module time_set_ctrl #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000,
  parameter logic [24:0] BLINK_DIV      = 25'd25_000_000
) (
  input  logic       clk,
  input  logic       clr_n,
  time_set_if.master bus
);

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    SET_H1 = 3'd1,
    SET_H0 = 3'd2,
    SET_M1 = 3'd3,
    SET_M0 = 3'd4,
    COMMIT = 3'd5
  } state_t;

  state_t      state_q;
  state_t      state_nxt;

  logic        mode_sync1, mode_sync2, mode_hist, mode_armed;
  logic        inc_sync1, inc_sync2, inc_hist, inc_armed;
  logic [1:0]  settle;
  logic        mode_pulse;
  logic        inc_pulse;

  logic [3:0]  h1, h0, m1, m0;

  logic        setting_c;
  logic [1:0]  sel_c;
  logic [3:0]  load_c;

  logic [24:0] blink_cnt;
  logic        blink_q;

  // Increment with wrap to zero once the digit reaches its top value.
  function automatic logic [3:0] inc_wrap(input logic [3:0] val, input logic [3:0] top);
    return (val >= top) ? 4'd0 : val + 4'd1;
  endfunction

  // Button synchronizers plus history flops; the edge detector compares
  // the second sync stage against the previous cycle's value.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      mode_sync1 <= 1'b0;
      mode_sync2 <= 1'b0;
      mode_hist  <= 1'b0;
      inc_sync1  <= 1'b0;
      inc_sync2  <= 1'b0;
      inc_hist   <= 1'b0;
    end else begin
      mode_sync1 <= bus.btn_mode;
      mode_sync2 <= mode_sync1;
      mode_hist  <= mode_sync2;
      inc_sync1  <= bus.btn_inc;
      inc_sync2  <= inc_sync1;
      inc_hist   <= inc_sync2;
    end
  end

  // Arming: the sync chain needs two cycles after reset to reflect the real
  // button level; a button only arms once it has been seen released, so one
  // held through reset cannot fire until it is released and pressed again.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      settle     <= 2'd0;
      mode_armed <= 1'b0;
      inc_armed  <= 1'b0;
    end else begin
      if (settle != 2'd2) settle <= settle + 2'd1;
      if (settle == 2'd2 && !mode_sync2) mode_armed <= 1'b1;
      if (settle == 2'd2 && !inc_sync2)  inc_armed  <= 1'b1;
    end
  end

  assign mode_pulse = mode_sync2 & ~mode_hist & mode_armed;
  assign inc_pulse  = inc_sync2  & ~inc_hist  & inc_armed;

`ifdef TIME_SET_TIMEOUT_EN
  logic [31:0] idle_cnt;

  // Idle counter: restarts on any button pulse or state change, runs only
  // while editing.
  always_ff @(posedge clk) begin
    if (!clr_n || mode_pulse || inc_pulse || state_nxt != state_q || !setting_c)
      idle_cnt <= 32'd0;
    else
      idle_cnt <= idle_cnt + 32'd1;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!clr_n) state_q <= RUN;
    else        state_q <= state_nxt;
  end

  // FSM next state and state-decoded outputs.
  always_comb begin
    state_nxt = state_q;
    setting_c = 1'b0;
    sel_c     = 2'd0;
    load_c    = 4'b0000;
    case (state_q)
      RUN: begin
        if (mode_pulse) state_nxt = SET_H1;
      end
      SET_H1: begin
        setting_c = 1'b1;
        sel_c     = 2'd3;
        if (mode_pulse) state_nxt = SET_H0;
      end
      SET_H0: begin
        setting_c = 1'b1;
        sel_c     = 2'd2;
        if (mode_pulse) state_nxt = SET_M1;
      end
      SET_M1: begin
        setting_c = 1'b1;
        sel_c     = 2'd1;
        if (mode_pulse) state_nxt = SET_M0;
      end
      SET_M0: begin
        setting_c = 1'b1;
        sel_c     = 2'd0;
        if (mode_pulse) state_nxt = COMMIT;
      end
      COMMIT: begin
        load_c    = 4'b1111;
        state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
`ifdef TIME_SET_TIMEOUT_EN
    if (setting_c && !mode_pulse && !inc_pulse && idle_cnt >= TIMEOUT_CYCLES - 32'd1)
      state_nxt = RUN;
`endif
  end

  // Shadow digits: captured from the live clock on entering edit, then only
  // changed by inc pulses; a simultaneous mode pulse discards the inc.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      h1 <= 4'd0;
      h0 <= 4'd0;
      m1 <= 4'd0;
      m0 <= 4'd0;
    end else if (state_q == RUN && mode_pulse) begin
      h1 <= bus.cur_h1;
      h0 <= bus.cur_h0;
      m1 <= bus.cur_m1;
      m0 <= bus.cur_m0;
    end else if (inc_pulse && !mode_pulse) begin
      case (state_q)
        SET_H1: begin
          h1 <= inc_wrap(h1, 4'd2);
          // Moving into the 20s must not leave an illegal hour like 27.
          if (h1 == 4'd1 && h0 > 4'd3) h0 <= 4'd3;
        end
        SET_H0:  h0 <= inc_wrap(h0, (h1 == 4'd2) ? 4'd3 : 4'd9);
        SET_M1:  m1 <= inc_wrap(m1, 4'd5);
        SET_M0:  m0 <= inc_wrap(m0, 4'd9);
        default: ;
      endcase
    end
  end

  // Blink divider: held clear outside edit, so it restarts from zero on
  // every entry to SET_H1.
  always_ff @(posedge clk) begin
    if (!clr_n || !setting_c) begin
      blink_cnt <= 25'd0;
      blink_q   <= 1'b0;
    end else if (blink_cnt == BLINK_DIV - 25'd1) begin
      blink_cnt <= 25'd0;
      blink_q   <= ~blink_q;
    end else begin
      blink_cnt <= blink_cnt + 25'd1;
    end
  end

  // Load is gated by clr_n so a reset landing on the COMMIT cycle never
  // reaches the digit counters.
  assign bus.load    = clr_n ? load_c : 4'b0000;
  assign bus.setting = setting_c;
  assign bus.sel     = sel_c;
  assign bus.blink   = blink_q & setting_c;
  assign bus.pst_h1  = h1;
  assign bus.pst_h0  = h0;
  assign bus.pst_m1  = m1;
  assign bus.pst_m0  = m0;

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 32'd500_000_000; idle cycles in edit before abort (used only with TIMEOUT_EN).
REQ-002 Parameter BLINK_DIV, default 25'd25_000_000; half-period of blink, in clk cycles.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 clr_n  input  1  synchronous, active-low reset.
REQ-005 btn_mode  input  1  raw mode button, asynchronous, active-high.
REQ-006 btn_inc  input  1  raw increment button, asynchronous, active-high.
REQ-007 cur_h1, cur_h0, cur_m1, cur_m0  input  4 each  live BCD digits read from the clock's digit counters.
REQ-008 pst_h1, pst_h0, pst_m1, pst_m0  output  4 each  preset values driven to the digit counters' pst inputs.
REQ-009 load  output  4  per-digit load strobe to the digit counters: bit3=h1, bit2=h0, bit1=m1, bit0=m0.
REQ-010 setting  output  1  high while in any edit state.
REQ-011 sel  output  2  digit being edited: 3=h1, 2=h0, 1=m1, 0=m0; 0 in RUN.
REQ-012 blink  output  1  square wave for the display to blank the selected digit; 0 outside edit.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer plus a history flop; the pulse SHALL be sync2 & ~hist, one cycle per rising press.
REQ-014 The FSM SHALL act on a pulse on the 3rd rising edge after the raw input first samples high.
REQ-015 States SHALL be RUN, SET_H1, SET_H0, SET_M1, SET_M0, COMMIT.
REQ-016 RUN + mode pulse: shadow digits <= cur_*; go to SET_H1.
REQ-017 Mode pulse SHALL advance SET_H1->SET_H0->SET_M1->SET_M0->COMMIT.
REQ-018 COMMIT SHALL last exactly one cycle with load=4'b1111 and pst_* = shadow digits, then go to RUN.
REQ-019 load SHALL be 4'b0000 in every state except COMMIT.
REQ-020 Inc pulse SHALL increment the selected shadow digit with wrap to 0: h1 wraps 2->0; h0 wraps 9->0, or 3->0 when h1==2; m1 wraps 5->0; m0 wraps 9->0.
REQ-021 When h1 increments to 2 and h0>3, h0 SHALL be clamped to 3 on the same edge.
REQ-022 Inc pulse in RUN or COMMIT SHALL be ignored.
REQ-023 If mode and inc pulse together: mode SHALL win and inc SHALL be discarded.
REQ-024 pst_* SHALL continuously reflect the shadow digits.
REQ-025 blink SHALL toggle every BLINK_DIV cycles while setting=1; its counter SHALL clear on entry to SET_H1.
REQ-026 cur_* changes during edit SHALL NOT affect the shadow digits.

Reset
REQ-027 On a rising edge with clr_n=0: state=RUN, shadow digits=0, load=0, setting=0, sel=0, blink=0, sync/history flops=0, counters=0.
REQ-028 Reset asserted mid-edit or during COMMIT SHALL abort with no load strobe on that edge or afterwards.
REQ-029 A button already held high when clr_n releases SHALL NOT produce a pulse until it is released and pressed again (history flop reset to 1 per sync stage is not used; sync2 and hist both clear, so a held button SHALL be masked by requiring hist<=sync2 for 2 cycles after release of reset).

Configuration
REQ-030 Macro TIME_SET_TIMEOUT_EN defined: an idle counter SHALL clear on any pulse or state change; reaching TIMEOUT_CYCLES in a SET_* state SHALL return to RUN with no load strobe.
REQ-031 Macro TIME_SET_TIMEOUT_EN undefined: no idle counter; edit states persist indefinitely.

Verification
REQ-032 cur=12:34, mode x1 -> setting=1, sel=3, shadow 1,2,3,4; mode x4 more -> one cycle load=1111, pst=12:34; then RUN.
REQ-033 SET_H1 with h1=1, h0=7: inc -> h1=2, h0=3; inc -> h1=0, h0 stays 3.
REQ-034 SET_M1 with m1=5: inc -> 0; SET_M0 with m0=9: inc -> 0; no carry into m1.
REQ-035 Assert mode and inc on the same cycle in SET_H0 -> sel=1, h0 unchanged.
REQ-036 clr_n=0 during COMMIT cycle -> load never pulses; all outputs 0 on next edge.
REQ-037 With TIME_SET_TIMEOUT_EN and TIMEOUT_CYCLES=100: enter SET_H1, idle 100 cycles -> RUN, setting=0, load stays 0000.
